// File: rtl/sub_share_pkg.sv
// Shared types and the round-robin pick function
// for the shared subtractor arbiter.
package sub_share_pkg;

    typedef enum logic {IDLE, FULL} sub_share_state_e;

    localparam int MAX_REQ     = 8;
    localparam int MAX_PTR_W   = 3;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

    // One-hot grant of the first valid index at or after ptr, modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   valid,
        input logic [MAX_PTR_W-1:0] ptr,
        input int                   n
    );
        logic [MAX_REQ-1:0]   g;
        logic                 found;
        logic [MAX_PTR_W-1:0] i3;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                i3 = MAX_PTR_W'((int'(ptr) + k) % n);
                if (!found && valid[i3]) begin
                    g[i3] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sub_share_arbiter_rr_grant_pick.sv
// Combinational round-robin picker: one-hot grant
// of the first valid requester starting at ptr_i.
module rr_grant_pick
    import sub_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [MAX_REQ-1:0]   v_ext;
    logic [MAX_PTR_W-1:0] p_ext;
    logic [MAX_REQ-1:0]   pick;

    always_comb begin
        v_ext = '0;
        v_ext[NUM_REQ-1:0] = valid_i;
        p_ext = '0;
        p_ext[PTR_W-1:0] = ptr_i;
        pick = rr_pick(v_ext, p_ext, NUM_REQ);
    end

    assign grant_o = pick[NUM_REQ-1:0];

endmodule

// File: rtl/sub_share_arbiter.sv
// One shared subtractor, round-robin arbitrated with
// optional burst lock and a single registered result slot.
module sub_share_arbiter
    import sub_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_h,
    input  logic                      rst_h,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W:0]           rsp_diff,
    output logic                      rsp_borrow,
    output logic [CNT_W-1:0]          op_count
);

    sub_share_state_e state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   lock_owner_q, lock_owner_d;
    logic              lock_vld_q, lock_vld_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W:0]   rsp_diff_q, rsp_diff_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic               can_issue;
    logic               lock_hit;
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] lock_oh;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               rsp_hs;
    logic [ID_W-1:0]    g_idx;
    logic [DATA_W-1:0]  a_sel;
    logic [DATA_W-1:0]  b_sel;

    rr_grant_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant)
    );

    assign can_issue = (state_q == IDLE) | rsp_ready;
    assign lock_hit  = lock_vld_q & req_valid[lock_owner_q];
    assign lock_oh   = NUM_REQ'(1) << lock_owner_q;
    assign grant     = lock_hit ? lock_oh : rr_grant;
    // Held low during reset so nothing looks accepted before state settles.
    assign req_ready = grant & {NUM_REQ{can_issue & ~rst_h}};
    assign accept    = |(req_ready & req_valid);
    assign rsp_hs    = (state_q == FULL) & rsp_ready;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx = ID_W'(i);
            end
        end
    end

    assign a_sel = req_a[g_idx*DATA_W +: DATA_W];
    assign b_sel = req_b[g_idx*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        lock_vld_d   = lock_vld_q;
        rsp_id_d     = rsp_id_q;
        rsp_diff_d   = rsp_diff_q;
        op_count_d   = op_count_q;

        if (lock_vld_q && !req_valid[lock_owner_q] && can_issue) begin
            lock_vld_d = 1'b0;
        end

        if (accept) begin
            state_d    = FULL;
            rsp_id_d   = g_idx;
            rsp_diff_d = {1'b0, a_sel} - {1'b0, b_sel};
            rr_ptr_d   = (g_idx == ID_W'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;
            lock_owner_d = req_lock[g_idx] ? g_idx : '0;
            lock_vld_d   = req_lock[g_idx];
        end else if (rsp_hs) begin
            state_d = IDLE;
        end

        if (rsp_hs && op_count_q != {CNT_W{1'b1}}) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            lock_vld_q   <= 1'b0;
            rsp_id_q     <= '0;
            rsp_diff_q   <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            lock_vld_q   <= lock_vld_d;
            rsp_id_q     <= rsp_id_d;
            rsp_diff_q   <= rsp_diff_d;
            op_count_q   <= op_count_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_diff   = rsp_diff_q;
    assign rsp_borrow = rsp_diff_q[DATA_W];
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Directed bench for sub_share_arbiter: reset, single ops,
// round-robin, backpressure, lock and mid-op reset.
module tb_sub_share_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk_h = 1'b0;
    logic          rst_h;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_lock;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0] req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [DW:0]   rsp_diff;
    logic          rsp_borrow;
    logic [CW-1:0] op_count;

    int passed = 0;
    int total  = 0;

    sub_share_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk_h      (clk_h),
        .rst_h      (rst_h),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_diff   (rsp_diff),
        .rsp_borrow (rsp_borrow),
        .op_count   (op_count)
    );

    always #5 clk_h = ~clk_h;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk_h);
    endtask

    function automatic logic [DW-1:0] a_of(input int i);
        return DW'(8'h10 * (i + 1));
    endfunction

    function automatic logic [DW-1:0] b_of(input int i);
        return DW'(i);
    endfunction

    task automatic load_table();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = a_of(i);
            req_b[i*DW +: DW] = b_of(i);
        end
    endtask

    initial begin
        rst_h     = 1'b1;
        req_valid = '1;
        req_lock  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset held two cycles with everyone requesting
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_rvalid", 32'(rsp_valid), 32'h0);
            chk("rst_cnt", 32'(op_count), 32'h0);
        end

        // Single ops on requester 0
        tick();
        rst_h = 1'b0;
        req_valid = 4'b0001;
        req_a[7:0] = 8'h05;
        req_b[7:0] = 8'h03;
        rsp_ready = 1'b1;
        #1;
        chk("s0_ready", 32'(req_ready), 32'h1);
        chk("s0_rvalid", 32'(rsp_valid), 32'h0);

        tick();
        req_a[7:0] = 8'h00;
        req_b[7:0] = 8'h01;
        #1;
        chk("s1_rvalid", 32'(rsp_valid), 32'h1);
        chk("s1_id", 32'(rsp_id), 32'h0);
        chk("s1_diff", 32'(rsp_diff), 32'h002);
        chk("s1_borrow", 32'(rsp_borrow), 32'h0);
        chk("s1_ready", 32'(req_ready), 32'h1);

        tick();
        req_valid = '0;
        #1;
        chk("s2_diff", 32'(rsp_diff), 32'h1FF);
        chk("s2_borrow", 32'(rsp_borrow), 32'h1);
        chk("s2_cnt", 32'(op_count), 32'h1);

        tick();
        #1;
        chk("s3_idle", 32'(rsp_valid), 32'h0);
        chk("s3_cnt", 32'(op_count), 32'h2);

        // Short reset to restart the pointer at 0
        rst_h = 1'b1;
        tick();
        rst_h = 1'b0;
        load_table();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        chk("rr_cnt_rst", 32'(op_count), 32'h0);

        // Round-robin, one result per cycle: ids 0,1,2,3,0
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                tick(); #1;
            end
            chk($sformatf("rr%0d_ready", k), 32'(req_ready),
                32'(1 << (k % 4)));
            chk($sformatf("rr%0d_cnt", k), 32'(op_count),
                32'((k > 0) ? k - 1 : 0));
            if (k > 0) begin
                chk($sformatf("rr%0d_id", k), 32'(rsp_id),
                    32'((k - 1) % 4));
                chk($sformatf("rr%0d_diff", k), 32'(rsp_diff),
                    32'(a_of((k - 1) % 4) - b_of((k - 1) % 4)));
            end
        end

        // Backpressure: result from requester 1 must hold
        for (int j = 0; j < 3; j++) begin
            tick();
            rsp_ready = 1'b0;
            #1;
            chk($sformatf("bp%0d_ready", j), 32'(req_ready), 32'h0);
            chk($sformatf("bp%0d_valid", j), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d_id", j), 32'(rsp_id), 32'h1);
            chk($sformatf("bp%0d_diff", j), 32'(rsp_diff), 32'h01F);
            chk($sformatf("bp%0d_cnt", j), 32'(op_count), 32'h5);
        end

        // Release: same-cycle accept of requester 2, which also locks
        tick();
        rsp_ready = 1'b1;
        req_lock = 4'b0100;
        #1;
        chk("bp_rel_ready", 32'(req_ready), 32'h4);
        chk("bp_rel_id", 32'(rsp_id), 32'h1);

        // Lock holds requester 2 despite the pointer sitting at 3
        tick();
        req_valid = 4'b0111;
        #1;
        chk("lk1_ready", 32'(req_ready), 32'h4);
        chk("lk1_id", 32'(rsp_id), 32'h2);
        chk("lk1_diff", 32'(rsp_diff), 32'h02E);
        chk("lk1_cnt", 32'(op_count), 32'h6);

        tick();
        req_lock = 4'b0000;
        #1;
        chk("lk2_ready", 32'(req_ready), 32'h4);
        chk("lk2_id", 32'(rsp_id), 32'h2);

        tick();
        #1;
        chk("lk3_ready", 32'(req_ready), 32'h1);
        chk("lk3_id", 32'(rsp_id), 32'h2);
        chk("lk3_cnt", 32'(op_count), 32'h8);

        // Stall a result, then reset while it is pending
        tick();
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        chk("mr0_valid", 32'(rsp_valid), 32'h1);
        chk("mr0_id", 32'(rsp_id), 32'h0);
        chk("mr0_diff", 32'(rsp_diff), 32'h010);
        chk("mr0_cnt", 32'(op_count), 32'h9);

        tick();
        rst_h = 1'b1;
        #1;
        chk("mr1_valid", 32'(rsp_valid), 32'h1);
        chk("mr1_ready", 32'(req_ready), 32'h0);

        tick();
        rst_h = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mr2_valid", 32'(rsp_valid), 32'h0);
        chk("mr2_cnt", 32'(op_count), 32'h0);
        chk("mr2_ready", 32'(req_ready), 32'h1);

        tick();
        req_valid = '0;
        #1;
        chk("mr3_valid", 32'(rsp_valid), 32'h1);
        chk("mr3_id", 32'(rsp_id), 32'h0);
        chk("mr3_diff", 32'(rsp_diff), 32'h010);
        chk("mr3_ready", 32'(req_ready), 32'h0);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
